// File: rtl/spi_master_ctrl_if.sv
// Command-side handshake between a register block / sequencer and the SPI controller.
// master: issues start/tx_data; slave: the controller that answers with ready/rx_data/rx_valid.
interface spi_master_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;

   modport master (
      output start,
      output tx_data,
      input  ready,
      input  rx_data,
      input  rx_valid
   );

   modport slave (
      input  start,
      input  tx_data,
      output ready,
      output rx_data,
      output rx_valid
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0, MSB-first, full-duplex SPI controller: one DATA_WIDTH-bit word per cs_n assertion,
// with programmable scl half-period and cs_n setup/hold, all timed in hclk cycles.
module spi_master_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned CS_SETUP   = 2,
   parameter int unsigned CS_HOLD    = 2
) (
   input  logic               hclk,
   input  logic               hresetn,
   spi_master_ctrl_if.slave   cmd,
   output logic               spi_scl,
   output logic               spi_cs_n,
   output logic               spi_mosi,
   input  logic               spi_miso
);

   localparam int unsigned CNT_MAX_SH = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned CNT_MAX    = (CNT_MAX_SH > CS_HOLD) ? CNT_MAX_SH : CS_HOLD;
   localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_e;

   state_e                state_q,    state_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic [BIT_W-1:0]      bit_q,      bit_d;
   logic [DATA_WIDTH-1:0] tx_sh_q,    tx_sh_d;
   logic [DATA_WIDTH-1:0] rx_sh_q,    rx_sh_d;
   logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  scl_q,      scl_d;
   logic                  cs_n_q,     cs_n_d;
   logic                  mosi_q,     mosi_d;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         scl_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         scl_q      <= scl_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      scl_d      = scl_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;

      unique case (state_q)
         IDLE: begin
            if (cmd.start) begin
               tx_sh_d = cmd.tx_data;
               mosi_d  = cmd.tx_data[DATA_WIDTH-1];
               rx_sh_d = '0;
               cnt_d   = '0;
               bit_d   = '0;
               cs_n_d  = 1'b0;
               state_d = SETUP;
            end
         end

         SETUP: begin
            if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         SHIFT: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!scl_q) begin
                  // miso is sampled on the same hclk edge that raises scl
                  scl_d      = 1'b1;
                  rx_sh_d    = rx_sh_q << 1;
                  rx_sh_d[0] = spi_miso;
               end else begin
                  scl_d = 1'b0;
                  if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                     state_d = HOLD;
                  end else begin
                     bit_d   = bit_q + BIT_W'(1);
                     tx_sh_d = tx_sh_q << 1;
                     mosi_d  = tx_sh_d[DATA_WIDTH-1];
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         HOLD: begin
            if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
               cnt_d      = '0;
               cs_n_d     = 1'b1;
               mosi_d     = 1'b0;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign cmd.ready    = (state_q == IDLE);
   assign cmd.rx_data  = rx_data_q;
   assign cmd.rx_valid = rx_valid_q;
   assign spi_scl      = scl_q;
   assign spi_cs_n     = cs_n_q;
   assign spi_mosi     = mosi_q;

endmodule
